// File: rtl/pingpong_buf_ctrl_pkg.sv
// Shared parameters and debug types for the ping-pong feature buffer.
package pingpong_buf_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 16;
  localparam int unsigned ADDR_W = 4;

  // Per-bank lifecycle, for debug/assertion views only; RTL stores full flags and pointers.
  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FILLING  = 2'd1,
    FULL     = 2'd2,
    DRAINING = 2'd3
  } bank_state_t;

endpackage

// File: rtl/pingpong_buf_ctrl_if.sv
// Producer/consumer handshake and mux-feed bundle of the ping-pong buffer.
interface pingpong_buf_ctrl_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_ready;
  logic              out_valid;
  logic [DATA_W-1:0] bank0_data;
  logic [DATA_W-1:0] bank1_data;
  logic              rd_sel;
  logic              bank_done;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, bank0_data, bank1_data, rd_sel, bank_done
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, bank0_data, bank1_data, rd_sel, bank_done
  );
endinterface

// File: rtl/pingpong_buf_ctrl_bank.sv
// One bank: DEPTH x DATA_W registers, one write port, one combinational read port.
module pingpong_bank #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pingpong_buf_ctrl.sv
// Ping-pong buffer: one bank fills from upstream while the other full bank drains.
module pingpong_buf_ctrl
  import pingpong_buf_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = pingpong_buf_ctrl_pkg::DATA_W,
  parameter int unsigned DEPTH  = pingpong_buf_ctrl_pkg::DEPTH,
  parameter int unsigned ADDR_W = pingpong_buf_ctrl_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  pingpong_buf_ctrl_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  logic              wr_bank, wr_bank_nxt;
  logic              rd_sel, rd_sel_nxt;
  logic [ADDR_W-1:0] wr_addr, wr_addr_nxt;
  logic [ADDR_W-1:0] rd_addr, rd_addr_nxt;
  logic [1:0]        full, full_nxt;
  logic              bank_done, bank_done_nxt;
  logic              in_ready, out_valid;
  logic              accept, consume;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_bank   <= 1'b0;
      rd_sel    <= 1'b0;
      wr_addr   <= '0;
      rd_addr   <= '0;
      full      <= '0;
      bank_done <= 1'b0;
    end else begin
      wr_bank   <= wr_bank_nxt;
      rd_sel    <= rd_sel_nxt;
      wr_addr   <= wr_addr_nxt;
      rd_addr   <= rd_addr_nxt;
      full      <= full_nxt;
      bank_done <= bank_done_nxt;
    end
  end

  // Next state; set and clear of full can hit different banks in the same cycle
  always_comb begin
    wr_bank_nxt   = wr_bank;
    rd_sel_nxt    = rd_sel;
    wr_addr_nxt   = wr_addr;
    rd_addr_nxt   = rd_addr;
    full_nxt      = full;
    bank_done_nxt = 1'b0;
    if (accept) begin
      if (wr_addr == LAST) begin
        full_nxt[wr_bank] = 1'b1;
        wr_bank_nxt       = ~wr_bank;
        wr_addr_nxt       = '0;
      end else begin
        wr_addr_nxt = wr_addr + 1'b1;
      end
    end
    if (consume) begin
      if (rd_addr == LAST) begin
        full_nxt[rd_sel] = 1'b0;
        rd_sel_nxt       = ~rd_sel;
        rd_addr_nxt      = '0;
        bank_done_nxt    = 1'b1;
      end else begin
        rd_addr_nxt = rd_addr + 1'b1;
      end
    end
  end

  // Outputs
  always_comb begin
    in_ready  = ~full[wr_bank];
    out_valid = full[rd_sel];
    accept    = bus.in_valid & in_ready;
    consume   = out_valid & bus.out_ready;
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.rd_sel    = rd_sel;
  assign bus.bank_done = bank_done;

  pingpong_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank0 (
    .clk   (clk),
    .we    (accept & ~wr_bank),
    .waddr (wr_addr),
    .wdata (bus.in_data),
    .raddr (rd_addr),
    .rdata (bus.bank0_data)
  );

  pingpong_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank1 (
    .clk   (clk),
    .we    (accept & wr_bank),
    .waddr (wr_addr),
    .wdata (bus.in_data),
    .raddr (rd_addr),
    .rdata (bus.bank1_data)
  );

  a_no_same_bank: assert property (@(posedge clk) disable iff (reset)
    !(accept && consume && (wr_bank == rd_sel)));
endmodule

// File: tb/tb_pingpong_buf_ctrl.sv
// Directed self-checking bench for the ping-pong buffer controller.
module tb_pingpong_buf_ctrl;
  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  pingpong_buf_ctrl_if #(.DATA_W(32)) bus ();

  pingpong_buf_ctrl #(.DATA_W(32), .DEPTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    int acc, cons, nf;
    logic [31:0] mux;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.in_data   = '0;
    reset = 1'b1;
    step();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_rd_sel", 32'(bus.rd_sel), 32'd0);
    check("rst_bank_done", 32'(bus.bank_done), 32'd0);
    reset = 1'b0;
    step();

    // out_ready while empty must not move the read pointer
    bus.out_ready = 1'b1;
    repeat (3) step();
    check("empty_out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;

    // Test 1: fill bank0
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 32'(i);
      step();
      if (i == 14) check("t1_not_yet_valid", 32'(bus.out_valid), 32'd0);
    end
    check("t1_out_valid", 32'(bus.out_valid), 32'd1);
    check("t1_rd_sel", 32'(bus.rd_sel), 32'd0);
    check("t1_bank0_data", bus.bank0_data, 32'h00);
    check("t1_in_ready", 32'(bus.in_ready), 32'd1);

    // Test 2: fill bank1, then stall
    for (int i = 16; i < 32; i++) begin
      bus.in_data = 32'(i);
      step();
    end
    check("t2_in_ready_low", 32'(bus.in_ready), 32'd0);
    check("t2_bank1_data", bus.bank1_data, 32'h10);
    bus.in_data = 32'h20;
    repeat (2) step();
    check("t2_held_in_ready", 32'(bus.in_ready), 32'd0);
    check("t2_held_bank0", bus.bank0_data, 32'h00);

    // Test 3: drain bank0
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t3_bank0_data", bus.bank0_data, 32'(i));
      check("t3_rd_sel", 32'(bus.rd_sel), 32'd0);
      if (i == 15) check("t3_done_early", 32'(bus.bank_done), 32'd0);
      step();
    end
    check("t3_bank_done", 32'(bus.bank_done), 32'd1);
    check("t3_rd_sel_after", 32'(bus.rd_sel), 32'd1);
    check("t3_bank1_data", bus.bank1_data, 32'h10);
    check("t3_in_ready", 32'(bus.in_ready), 32'd1);
    check("t3_out_valid", 32'(bus.out_valid), 32'd1);
    bus.out_ready = 1'b0;
    step();
    check("t3_done_pulse", 32'(bus.bank_done), 32'd0);

    // Tests 4/5: continuous streaming against a counting model
    do_reset();
    acc  = 0;
    cons = 0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && cons < 64; cyc++) begin
      bus.in_valid = (acc < 64);
      bus.in_data  = 32'h100 + 32'(acc);
      nf = acc / 16 - cons / 16;
      mux = bus.rd_sel ? bus.bank1_data : bus.bank0_data;
      check("t4_in_ready", 32'(bus.in_ready), 32'(nf < 2));
      check("t4_out_valid", 32'(bus.out_valid), 32'(nf > 0));
      if (nf > 0) begin
        check("t4_data", mux, 32'h100 + 32'(cons));
        check("t4_rd_sel", 32'(bus.rd_sel), 32'((cons / 16) % 2));
      end
      if (bus.in_valid && nf < 2) acc++;
      if (nf > 0) cons++;
      step();
      if (acc == 32 && cons == 16) begin
        check("t5_simul_out_valid", 32'(bus.out_valid), 32'd1);
        check("t5_simul_rd_sel", 32'(bus.rd_sel), 32'd1);
        check("t5_simul_in_ready", 32'(bus.in_ready), 32'd1);
        check("t5_simul_done", 32'(bus.bank_done), 32'd1);
      end
    end
    check("t4_stream_count", 32'(cons), 32'd64);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;

    // Test 6: async reset mid-fill
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_data = 32'h50 + 32'(i);
      step();
    end
    bus.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    check("t6_in_ready", 32'(bus.in_ready), 32'd1);
    check("t6_out_valid", 32'(bus.out_valid), 32'd0);
    check("t6_rd_sel", 32'(bus.rd_sel), 32'd0);
    step();
    reset = 1'b0;
    step();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.in_data = 32'hA0 + 32'(i);
      step();
      if (i == 14) check("t6_refill_not_valid", 32'(bus.out_valid), 32'd0);
    end
    check("t6_refill_valid", 32'(bus.out_valid), 32'd1);
    check("t6_refill_data", bus.bank0_data, 32'hA0);
    bus.in_valid = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
